// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: game FSM for a two-obstacle scroller. Paces obstacle
// steps with a speed-adjusted timer, respawns obstacles with LFSR-derived
// gap heights, counts passed obstacles and detects player collisions.
module obstacle_scheduler #(
    parameter int TIME_MAX   = 4000000,
    parameter int SPAWN_X    = 670,
    parameter int SPACING    = 335,
    parameter int T_W        = 29,
    parameter int S_Z        = 120,
    parameter int P_X        = 100,
    parameter int P_SIZE     = 16,
    parameter int SPEED_STEP = 200000,
    parameter int SPEED_MAX  = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  p_y,
    output logic        move_tick,
    output logic [9:0]  o1_x,
    output logic [9:0]  o2_x,
    output logic [9:0]  S_H1,
    output logic [9:0]  S_H2,
    output logic [25:0] speed_offset,
    output logic [7:0]  score,
    output logic [1:0]  state,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_t;

    localparam logic [9:0]  X_SPAWN1 = 10'(SPAWN_X);
    localparam logic [9:0]  X_SPAWN2 = 10'(SPAWN_X + SPACING);
    localparam logic [9:0]  H_INIT   = 10'd185;
    localparam logic [9:0]  X_PLAYER = 10'(P_X);
    localparam logic [11:0] X_HI     = 12'(P_X + P_SIZE + T_W - 2);
    localparam logic [11:0] PY_OFF   = 12'(P_SIZE - 1);
    localparam logic [11:0] GAP_OFF  = 12'(S_Z - 1);
    localparam logic [11:0] FLOOR_Y  = 12'd479;
    localparam logic [15:0] SEED     = 16'hACE1;

    state_t      st;
    logic [25:0] timer;
    logic [15:0] lfsr;

    // Gap height from a random byte; out-of-range values fold to the default.
    function automatic logic [9:0] new_h(input logic [7:0] r);
        return (r <= 8'd210) ? 10'd20 + 10'(r) : H_INIT;
    endfunction

    logic        active, expire, step, fb;
    logic [25:0] limit;
    logic [11:0] py_bot;
    logic        in1, in2, hit1, hit2, floor_hit, collide;
    logic [9:0]  o1_nxt, o2_nxt, h1_nxt, h2_nxt;
    logic [8:0]  score_sum;
    logic [7:0]  score_nxt;
    logic        bump;
    logic [26:0] speed_sum;
    logic [25:0] speed_nxt;

    assign state  = st;
    assign fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign active = (st == PLAY) || (st == HIT);
    assign limit  = 26'(TIME_MAX) - speed_offset;
    assign expire = active && (timer == limit);
    assign step   = move_tick && (st == PLAY);

    // Player box versus each pipe column, plus the floor line.
    assign py_bot    = {2'b0, p_y} + PY_OFF;
    assign in1       = (o1_x >= X_PLAYER) && ({2'b0, o1_x} <= X_HI);
    assign in2       = (o2_x >= X_PLAYER) && ({2'b0, o2_x} <= X_HI);
    assign hit1      = in1 && ((p_y < S_H1) || (py_bot >= {2'b0, S_H1} + GAP_OFF));
    assign hit2      = in2 && ((p_y < S_H2) || (py_bot >= {2'b0, S_H2} + GAP_OFF));
    assign floor_hit = py_bot >= FLOOR_Y;
    assign collide   = hit1 || hit2 || floor_hit;

    // Obstacle 2 takes the high byte only when both respawn together.
    assign o1_nxt = (o1_x == 10'd0) ? X_SPAWN1 : o1_x - 10'd1;
    assign o2_nxt = (o2_x == 10'd0) ? X_SPAWN1 : o2_x - 10'd1;
    assign h1_nxt = (o1_x == 10'd0) ? new_h(lfsr[7:0]) : S_H1;
    assign h2_nxt = (o2_x == 10'd0) ? new_h((o1_x == 10'd0) ? lfsr[15:8] : lfsr[7:0]) : S_H2;

    // A pass is an obstacle stepping from the player's x to one left of it.
    assign score_sum = {1'b0, score} + 9'(o1_x == X_PLAYER) + 9'(o2_x == X_PLAYER);
    assign score_nxt = score_sum[8] ? 8'd255 : score_sum[7:0];
    assign bump      = (score_nxt / 8'd5) != (score / 8'd5);
    assign speed_sum = {1'b0, speed_offset} + 27'(SPEED_STEP);
    assign speed_nxt = (speed_sum > 27'(SPEED_MAX)) ? 26'(SPEED_MAX) : speed_sum[25:0];

    // Game FSM with timer, LFSR and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= IDLE;
            timer        <= '0;
            lfsr         <= SEED;
            move_tick    <= 1'b0;
            o1_x         <= X_SPAWN1;
            o2_x         <= X_SPAWN2;
            S_H1         <= H_INIT;
            S_H2         <= H_INIT;
            score        <= '0;
            speed_offset <= '0;
            game_over    <= 1'b0;
        end else begin
            lfsr      <= {lfsr[14:0], fb};
            move_tick <= expire && (st == PLAY);
            if (active) timer <= expire ? 26'd0 : timer + 26'd1;
            else        timer <= '0;
            case (st)
                IDLE: if (start) begin
                    st           <= PLAY;
                    timer        <= '0;
                    o1_x         <= X_SPAWN1;
                    o2_x         <= X_SPAWN2;
                    S_H1         <= H_INIT;
                    S_H2         <= H_INIT;
                    score        <= '0;
                    speed_offset <= '0;
                end
                PLAY: begin
                    if (step) begin
                        o1_x  <= o1_nxt;
                        o2_x  <= o2_nxt;
                        S_H1  <= h1_nxt;
                        S_H2  <= h2_nxt;
                        score <= score_nxt;
                        if (bump) speed_offset <= speed_nxt;
                    end
                    if (collide) st <= HIT;
                end
                HIT: if (expire) begin
                    st        <= OVER;
                    game_over <= 1'b1;
                end
                OVER: if (start) begin
                    st        <= IDLE;
                    game_over <= 1'b0;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
module tb_obstacle_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        st  [3];
    logic [9:0]  py  [3];
    logic        mt  [3];
    logic        go  [3];
    logic [9:0]  o1  [3];
    logic [9:0]  o2  [3];
    logic [9:0]  h1  [3];
    logic [9:0]  h2  [3];
    logic [25:0] spd [3];
    logic [7:0]  sc  [3];
    logic [1:0]  sta [3];

    obstacle_scheduler #(.TIME_MAX(10)) dut_a (
        .clk(clk), .reset(rst[0]), .start(st[0]), .p_y(py[0]), .move_tick(mt[0]),
        .o1_x(o1[0]), .o2_x(o2[0]), .S_H1(h1[0]), .S_H2(h2[0]), .speed_offset(spd[0]),
        .score(sc[0]), .state(sta[0]), .game_over(go[0]));

    obstacle_scheduler #(.TIME_MAX(10), .SPAWN_X(20), .SPACING(5), .S_Z(600), .P_X(10),
                         .SPEED_STEP(3), .SPEED_MAX(6)) dut_b (
        .clk(clk), .reset(rst[1]), .start(st[1]), .p_y(py[1]), .move_tick(mt[1]),
        .o1_x(o1[1]), .o2_x(o2[1]), .S_H1(h1[1]), .S_H2(h2[1]), .speed_offset(spd[1]),
        .score(sc[1]), .state(sta[1]), .game_over(go[1]));

    obstacle_scheduler #(.TIME_MAX(10), .SPAWN_X(110)) dut_c (
        .clk(clk), .reset(rst[2]), .start(st[2]), .p_y(py[2]), .move_tick(mt[2]),
        .o1_x(o1[2]), .o2_x(o2[2]), .S_H1(h1[2]), .S_H2(h2[2]), .speed_offset(spd[2]),
        .score(sc[2]), .state(sta[2]), .game_over(go[2]));

    typedef struct {
        int          inst;
        int          sig;
        logic        direct;
        logic [31:0] act;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    logic [15:0] m_lfsr;
    always @(posedge clk)
        if (rst[0]) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    function automatic logic [9:0] hmodel(input logic [7:0] r);
        return (r <= 8'd210) ? 10'd20 + 10'(r) : 10'd185;
    endfunction

    function automatic logic [31:0] sample(input int i, input int s);
        case (s)
            0: return 32'(sta[i]);
            1: return 32'(o1[i]);
            2: return 32'(o2[i]);
            3: return 32'(h1[i]);
            4: return 32'(h2[i]);
            5: return 32'(sc[i]);
            6: return 32'(spd[i]);
            7: return 32'(go[i]);
            8: return 32'(mt[i]);
            default: return '1;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = e.direct ? e.act : sample(e.inst, e.sig);
            checks++;
            if (a === e.exp) passes++;
            else $display("FAIL %s: actual %0d required %0d", e.name, a, e.exp);
        end
    end

    task automatic check(input int i, input int s, input logic [31:0] v, input string n);
        logic [31:0] a;
        a = sample(i, s);
        checks++;
        if (a === v) passes++;
        else $display("FAIL %s: actual %0d required %0d", n, a, v);
    endtask

    task automatic exp_sig(input int i, input int s, input logic [31:0] v, input string n);
        exp_t e;
        e.inst = i; e.sig = s; e.direct = 1'b0; e.act = '0; e.exp = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic exp_val(input logic [31:0] a, input logic [31:0] v, input string n);
        exp_t e;
        e.inst = 0; e.sig = 0; e.direct = 1'b1; e.act = a; e.exp = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_reset(input int i, input int x1, input int x2);
        check(i, 0, 0,   $sformatf("rst%0d_state", i));
        check(i, 1, x1,  $sformatf("rst%0d_o1_x", i));
        check(i, 2, x2,  $sformatf("rst%0d_o2_x", i));
        check(i, 3, 185, $sformatf("rst%0d_S_H1", i));
        check(i, 4, 185, $sformatf("rst%0d_S_H2", i));
        check(i, 5, 0,   $sformatf("rst%0d_score", i));
        check(i, 6, 0,   $sformatf("rst%0d_speed", i));
        check(i, 7, 0,   $sformatf("rst%0d_game_over", i));
        check(i, 8, 0,   $sformatf("rst%0d_move_tick", i));
    endtask

    initial begin
        int          n;
        logic        found;
        logic [9:0]  po;
        logic [15:0] pl;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            st[i]  = 1'b0;
            py[i]  = 10'd200;
        end
        py[1] = 10'd240;
        tick(2);
        chk_reset(0, 670, 1005);
        chk_reset(1, 20, 25);
        chk_reset(2, 110, 445);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        tick(1);

        st[0] = 1'b1; tick(1); st[0] = 1'b0;
        exp_sig(0, 0, 1, "a_play_after_start");
        n = 0;
        while (!mt[0] && n < 40) begin tick(1); n++; end
        exp_val(n, 11, "a_first_tick_latency");
        exp_sig(0, 1, 670, "a_o1_before_step");
        tick(1);
        exp_sig(0, 1, 669, "a_o1_after_step");
        exp_sig(0, 8, 0, "a_tick_single_cycle");
        n = 1;
        while (!mt[0] && n < 40) begin tick(1); n++; end
        exp_val(n, 11, "a_tick_period");

        found = 1'b0; n = 0; pl = '0;
        while (!found && n < 9000) begin
            po = o1[0];
            pl = m_lfsr;
            tick(1);
            n++;
            if (po == 10'd0 && o1[0] == 10'd670) found = 1'b1;
        end
        exp_val(32'(found), 1, "a_wrap_seen");
        exp_sig(0, 3, 32'(hmodel(pl[7:0])), "a_S_H1_respawn");
        exp_sig(0, 4, 185, "a_S_H2_unchanged");
        exp_sig(0, 5, 1, "a_score_after_pass");
        exp_sig(0, 2, 334, "a_o2_at_wrap");
        exp_sig(0, 0, 1, "a_still_play");

        py[0] = 10'd470; tick(1);
        exp_sig(0, 0, 2, "a_floor_hit");
        tick(12);
        check(0, 0, 3, "a_over_after_expiry");
        check(0, 7, 1, "a_game_over");
        exp_sig(0, 1, 670, "a_o1_frozen");
        exp_sig(0, 2, 334, "a_o2_frozen");
        exp_sig(0, 5, 1, "a_score_frozen");
        exp_sig(0, 8, 0, "a_no_tick_in_over");
        st[0] = 1'b1; tick(1); st[0] = 1'b0;
        exp_sig(0, 0, 0, "a_idle_after_ack");
        exp_sig(0, 7, 0, "a_game_over_clear");

        st[2] = 1'b1; tick(1); st[2] = 1'b0;
        exp_sig(2, 0, 1, "c_play");
        exp_sig(2, 1, 110, "c_o1_spawn");
        tick(1);
        st[2] = 1'b1; tick(1); st[2] = 1'b0;
        exp_sig(2, 0, 1, "c_start_ignored_play");
        py[2] = 10'd0; tick(1);
        exp_sig(2, 0, 2, "c_pipe_hit");
        st[2] = 1'b1; tick(1); st[2] = 1'b0;
        exp_sig(2, 0, 2, "c_start_ignored_hit");
        n = 0;
        while (sta[2] != 2'd3 && n < 20) begin tick(1); n++; end
        exp_sig(2, 0, 3, "c_over");
        exp_sig(2, 7, 1, "c_game_over");
        exp_sig(2, 1, 110, "c_o1_frozen");
        st[2] = 1'b1; tick(1); st[2] = 1'b0;
        exp_sig(2, 0, 0, "c_idle");

        st[1] = 1'b1; tick(1); st[1] = 1'b0;
        exp_sig(1, 0, 1, "b_play");
        n = 0;
        while (sc[1] < 8'd5 && n < 2000) begin tick(1); n++; end
        exp_sig(1, 5, 5, "b_score_five");
        exp_sig(1, 6, 3, "b_speed_step");
        exp_sig(1, 1, 9, "b_o1_at_fifth_pass");
        exp_sig(1, 2, 14, "b_o2_at_fifth_pass");
        n = 0;
        while (!mt[1] && n < 40) begin tick(1); n++; end
        tick(1);
        n = 1;
        while (!mt[1] && n < 40) begin tick(1); n++; end
        exp_val(n, 8, "b_fast_period");
        n = 0;
        while (sc[1] < 8'd15 && n < 4000) begin tick(1); n++; end
        exp_sig(1, 5, 15, "b_score_fifteen");
        exp_sig(1, 6, 6, "b_speed_clamped");

        rst[1] = 1'b1; tick(1); rst[1] = 1'b0;
        st[1] = 1'b1; tick(1); st[1] = 1'b0;
        n = 0;
        while (sc[1] < 8'd3 && n < 2000) begin tick(1); n++; end
        exp_sig(1, 5, 3, "b_score_three");
        exp_sig(1, 0, 1, "b_play_before_reset");
        rst[1] = 1'b1; st[1] = 1'b1; tick(1); rst[1] = 1'b0; st[1] = 1'b0;
        chk_reset(1, 20, 25);
        tick(1);
        exp_sig(1, 0, 0, "b_idle_after_reset");

        tick(2);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
